// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one word-organised memory between fetch (port 0)
// and load/store (port 1). Optional build macro: ARB_MISALIGN_CHK_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rsp_valid,
  output logic [31:0]       p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rsp_valid,
  output logic [31:0]       p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]        r_wait0;
  logic              r_p0_rsp_valid;
  logic [31:0]       r_p0_rsp_rdata;
  logic              r_p0_rsp_err;
  logic              r_p1_rsp_valid;
  logic [31:0]       r_p1_rsp_rdata;
  logic              r_p1_rsp_err;

  logic              w_force0;
  logic              w_p0_gnt;
  logic              w_p1_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_reject;
  logic [31:0]       w_rdata;

  // Port 1 wins contention unless port 0 has waited MAX_WAIT cycles.
  assign w_force0 = (r_wait0 == C_MAX_WAIT);
  assign w_p0_gnt = p0_req && (!p1_req || w_force0);
  assign w_p1_gnt = p1_req && !(p0_req && w_force0);

  assign w_addr = w_p0_gnt ? p0_addr :
                  w_p1_gnt ? p1_addr : '0;

`ifdef ARB_MISALIGN_CHK_EN
  assign w_reject = (w_p0_gnt || w_p1_gnt) && (w_addr[1:0] != 2'b00);
`else
  assign w_reject = 1'b0;
`endif

  assign w_rdata = w_reject ? 32'h0 : mem_rdata;

  assign p0_gnt    = w_p0_gnt;
  assign p1_gnt    = w_p1_gnt;
  assign mem_addr  = w_addr;
  assign mem_wdata = p1_wdata;
  assign mem_we    = w_p1_gnt && p1_we && !w_reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait0 <= 4'd0;
    end else if (p0_req && !w_p0_gnt) begin
      if (r_wait0 != C_MAX_WAIT) begin
        r_wait0 <= r_wait0 + 4'd1;
      end
    end else begin
      r_wait0 <= 4'd0;
    end
  end

  // Response data holds its last value between grants; valid is a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_rsp_valid <= 1'b0;
      r_p0_rsp_rdata <= 32'h0;
      r_p0_rsp_err   <= 1'b0;
      r_p1_rsp_valid <= 1'b0;
      r_p1_rsp_rdata <= 32'h0;
      r_p1_rsp_err   <= 1'b0;
    end else begin
      r_p0_rsp_valid <= w_p0_gnt;
      r_p1_rsp_valid <= w_p1_gnt;
      if (w_p0_gnt) begin
        r_p0_rsp_rdata <= w_rdata;
        r_p0_rsp_err   <= w_reject;
      end
      if (w_p1_gnt) begin
        r_p1_rsp_rdata <= w_rdata;
        r_p1_rsp_err   <= w_reject;
      end
    end
  end

  assign p0_rsp_valid = r_p0_rsp_valid;
  assign p0_rsp_rdata = r_p0_rsp_rdata;
  assign p0_rsp_err   = r_p0_rsp_err;
  assign p1_rsp_valid = r_p1_rsp_valid;
  assign p1_rsp_rdata = r_p1_rsp_rdata;
  assign p1_rsp_err   = r_p1_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed and random checks of mem_port_arbiter
// against a transaction-level reference model. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int ADDR_W   = 32;
`ifdef ARB_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              p0_req = 1'b0;
  logic [ADDR_W-1:0] p0_addr = '0;
  logic              p0_gnt, p0_rsp_valid, p0_rsp_err;
  logic [31:0]       p0_rsp_rdata;
  logic              p1_req = 1'b0, p1_we = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [31:0]       p1_wdata = '0;
  logic              p1_gnt, p1_rsp_valid, p1_rsp_err;
  logic [31:0]       p1_rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_we;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_wait   = 0;
  logic m_v0 = 0, m_v1 = 0, m_e0 = 0, m_e1 = 0;
  logic [31:0] m_d0 = 0, m_d1 = 0;
  logic s_g0 = 0, s_g1 = 0, s_we = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Memory instance: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
  task automatic tick();
    logic        g0, g1, rej;
    logic [31:0] a;
    int          idx;
    @(negedge clk);
    chk("p0_rsp_valid", p0_rsp_valid, m_v0);
    chk("p1_rsp_valid", p1_rsp_valid, m_v1);
    if (m_v0) begin
      chk("p0_rsp_rdata", p0_rsp_rdata, m_d0);
      chk("p0_rsp_err", p0_rsp_err, m_e0);
    end
    if (m_v1) begin
      chk("p1_rsp_rdata", p1_rsp_rdata, m_d1);
      chk("p1_rsp_err", p1_rsp_err, m_e1);
    end
    if (p0_req && p1_req) begin
      g0 = (m_wait == MAX_WAIT);
      g1 = !g0;
    end else begin
      g0 = p0_req;
      g1 = p1_req;
    end
    a   = g0 ? p0_addr : (g1 ? p1_addr : 32'h0);
    rej = MIS && (g0 || g1) && (a[1:0] != 2'b00);
    idx = int'(a[7:2]);
    chk("p0_gnt", p0_gnt, g0);
    chk("p1_gnt", p1_gnt, g1);
    chk("mem_addr", mem_addr, a);
    chk("mem_we", mem_we, g1 && p1_we && !rej);
    chk("mem_wdata", mem_wdata, p1_wdata);
    s_g0 = p0_gnt; s_g1 = p1_gnt; s_we = mem_we;
    m_v0 = g0;
    m_v1 = g1;
    if (g0) begin m_d0 = rej ? 32'h0 : ref_mem[idx]; m_e0 = rej; end
    if (g1) begin m_d1 = rej ? 32'h0 : ref_mem[idx]; m_e1 = rej; end
    if (g1 && p1_we && !rej) ref_mem[idx] = p1_wdata;
    if (p0_req && !g0) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_v0 = 0; m_v1 = 0; m_e0 = 0; m_e1 = 0; m_d0 = 0; m_d1 = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom % 64) * 4;
    if ($urandom % 4 == 0) a = a + ($urandom % 4);
    return a;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_p0v"}, p0_rsp_valid, 0);
    chk({tag, "_p1v"}, p1_rsp_valid, 0);
    chk({tag, "_p0d"}, p0_rsp_rdata, 0);
    chk({tag, "_p1d"}, p1_rsp_rdata, 0);
    chk({tag, "_p0e"}, p0_rsp_err, 0);
    chk({tag, "_p1e"}, p1_rsp_err, 0);
    chk({tag, "_gnt"}, {p0_gnt, p1_gnt}, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[2] = 32'hDEADBEEF;
    ref_mem[2] = 32'hDEADBEEF;

    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uncontended port 0 read
    p0_req = 1; p0_addr = 32'h8;
    tick();
    chk("t1_gnt", s_g0, 1);
    chk("t1_valid", p0_rsp_valid, 1);
    chk("t1_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    p0_req = 0;
    tick();

    // Port 1 write then read-back
    p1_req = 1; p1_we = 1; p1_addr = 32'h4; p1_wdata = 32'h12345678;
    tick();
    chk("t2_wack", p1_rsp_valid, 1);
    p1_we = 0; p1_wdata = 32'h0;
    tick();
    chk("t2_rdback", p1_rsp_rdata, 32'h12345678);
    p1_req = 0;
    tick();

    // Continuous contention: port 0 wins every fifth cycle
    p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_p0_pattern", s_g0, (i % 5) == 4);
      chk("t3_p1_pattern", s_g1, (i % 5) != 4);
    end
    p0_req = 0; p1_req = 0;
    tick();

`ifdef ARB_MISALIGN_CHK_EN
    p1_req = 1; p1_we = 1; p1_addr = 32'h6; p1_wdata = 32'hFFFFFFFF;
    tick();
    chk("t4_we", s_we, 0);
    chk("t4_err", p1_rsp_err, 1);
    chk("t4_rdata", p1_rsp_rdata, 0);
    chk("t4_mem", mem[1], 32'h12345678);
`else
    p1_req = 1; p1_we = 0; p1_addr = 32'h6;
    tick();
    chk("t4_err", p1_rsp_err, 0);
    chk("t4_rdata", p1_rsp_rdata, 32'h12345678);
`endif
    p1_req = 0; p1_we = 0; p1_wdata = 0;
    tick();

    // Asynchronous reset while a grant is pending
    p0_req = 1; p0_addr = 32'h0; p1_req = 1; p1_addr = 32'h4;
    tick();
    tick();
    @(negedge clk);
    chk("t5_pre_gnt", p1_gnt, 1);
    #2;
    rst_n = 0;
    p0_req = 0; p1_req = 0; p0_addr = 0; p1_addr = 0; p1_wdata = 0;
    model_reset();
    #1;
    check_idle_outputs("t5_async");
    @(posedge clk); #1;
    check_idle_outputs("t5_after");
    #2;
    rst_n = 1;
    p0_req = 1; p1_req = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_wait_cleared", s_g0, i == 4);
    end
    p0_req = 0; p1_req = 0;
    tick();

    // Random traffic obeying the hold-until-grant rule
    s_g0 = 0; s_g1 = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!p0_req || s_g0) begin
        p0_req  = ($urandom % 3) != 0;
        p0_addr = rand_addr();
      end
      if (!p1_req || s_g1) begin
        p1_req   = ($urandom % 3) != 0;
        p1_addr  = rand_addr();
        p1_we    = $urandom % 2;
        p1_wdata = $urandom;
      end
      tick();
    end
    p0_req = 0; p1_req = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single-port, word-organised data/instruction memory between the instruction-fetch unit (port 0, read-only) and the load/store unit (port 1, read/write). It grants one access per cycle, drives the memory's address/write-data/write-enable, and returns a registered response one cycle after the grant. Port 1 has fixed priority, backed by a starvation counter that guarantees port 0 forward progress. The block sits between the core's fetch/LSU and the memory instance.

## Interface
- `MAX_WAIT`, default 4: consecutive denied cycles after which port 0 is force-granted (1..15)
- `ADDR_W`, default 32: address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `p0_req`  in  1  port 0 read request
- `p0_addr`  in  ADDR_W  port 0 byte address
- `p0_gnt`  out  1  port 0 granted this cycle (combinational)
- `p0_rsp_valid`  out  1  port 0 response valid (registered, 1-cycle pulse)
- `p0_rsp_rdata`  out  32  port 0 read data
- `p0_rsp_err`  out  1  port 0 access rejected (misaligned)
- `p1_req`, `p1_we`  in  1 each  port 1 request / write qualifier
- `p1_addr`  in  ADDR_W  port 1 byte address
- `p1_wdata`  in  32  port 1 write data
- `p1_gnt`, `p1_rsp_valid`, `p1_rsp_rdata` (32), `p1_rsp_err`: as port 0
- `mem_addr`  out  ADDR_W  to memory address
- `mem_wdata`  out  32  to memory write data
- `mem_we`  out  1  to memory write enable
- `mem_rdata`  in  32  from memory, combinational read data

## Operation
- Arbitration is combinational each cycle, with `force0 = (wait0 == MAX_WAIT)`.
  - Only one requester active: that requester is granted.
  - Both active and `!force0`: port 1 is granted.
  - Both active and `force0`: port 0 is granted.
- At most one of `p0_gnt`/`p1_gnt` is high in any cycle.
- `wait0` (4-bit counter) behaviour:
  - increments when `p0_req && !p0_gnt`;
  - clears when `p0_gnt` or `!p0_req`;
  - saturates at `MAX_WAIT`.
- Memory drive:
  - granted port's address goes to `mem_addr`;
  - `mem_we = p1_gnt && p1_we && !reject`;
  - `mem_wdata = p1_wdata`;
  - with no grant: `mem_addr = 0`, `mem_we = 0`.
- Requester rule: a requester holds `req` and its payload stable until it sees `gnt`. It may deassert or present a new request in the cycle after `gnt`.
- Response capture, at the grant edge:
  - `rsp_valid` is set for the granted port only;
  - `rsp_rdata` captures `mem_rdata`;
  - `rsp_err` captures `reject`.
- Writes:
  - `p1_rsp_valid` pulses as the write acknowledge;
  - `p1_rsp_rdata` carries the pre-write word.
- A rejected access has `rsp_rdata = 0`, and no write occurs.
- Reset values: all `rsp_valid`, `rsp_err` and `rsp_rdata` are 0; `wait0 = 0`.
- Reset mid-operation: any pending response is discarded, and no `rsp_valid` is produced for the interrupted grant.

## Timing
- Grant latency: 0 cycles (same cycle as `req`, when uncontended).
- Response latency: `rsp_valid` is high exactly in cycle N+1 for a grant in cycle N, for one cycle.
- Sustained throughput: one access per cycle in total. Back-to-back grants yield back-to-back `rsp_valid` pulses.
- Worst-case port 0 grant delay under continuous port 1 traffic: `MAX_WAIT` cycles after `req` assertion.
- A write granted in cycle N is visible to a read granted in cycle N+1 or later.

## Configuration
- `ARB_MISALIGN_CHK_EN`:
  - defined: `reject = (granted addr[1:0] != 2'b00)`. A rejected access gets `rsp_err = 1`, `rsp_rdata = 0` and suppressed `mem_we`, but still receives `gnt` and `rsp_valid`.
  - undefined: `reject` is tied to 0, `rsp_err` outputs are constant 0, and the address is passed unmodified to memory.

## Test plan
- Reset, then `p0_req`, `p0_addr = 0x8`, with mem[0x8] = 0xDEADBEEF -> `p0_gnt` in the same cycle; next cycle `p0_rsp_valid = 1` and `p0_rsp_rdata = 0xDEADBEEF`.
- `p1` write 0x12345678 to 0x4, then `p1` read 0x4 -> write ack pulse; the following read returns 0x12345678.
- `p0_req` and `p1_req` held high continuously with `MAX_WAIT = 4` -> `p1` granted for 4 cycles, `p0` granted on the 5th cycle; pattern repeats and `wait0` never exceeds 4.
- With `ARB_MISALIGN_CHK_EN`: `p1` write 0xFFFFFFFF to 0x6 -> `mem_we = 0`, `p1_rsp_err = 1`, `p1_rsp_rdata = 0`, memory unchanged.
- `rst_n` asserted asynchronously mid-cycle after a grant -> no `rsp_valid` the next cycle, all outputs 0, `wait0 = 0`.
- Random `req` traffic for 10k cycles -> never two grants in one cycle, every grant is followed by exactly one `rsp_valid`, and the responses match a scoreboard memory model.
